// File: rtl/obstacle_speed_scheduler.sv
// Obstacle scroll pacer: turns 60 Hz ticks into per-tick pixel steps via a
// fractional phase accumulator; speed level rises with the score's hundreds digit.
// Optional SPEED_SCHED_BOOST_EN adds button_boost, which doubles the increment in RUN.
//
// state  | meaning
// IDLE   | after reset, waiting for the first game_start; ticks ignored
// RUN    | game active; ticks produce steps, score changes raise the level
// FROZEN | game over / paused; ticks ignored, accumulator held
module obstacle_speed_scheduler #(
  parameter int FRAC_BITS = 4,
  parameter int BASE_INC  = 16,
  parameter int LEVEL_INC = 4,
  parameter int MAX_LEVEL = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_tick,
  input  logic        game_start,
  input  logic        game_frozen,
  input  logic [15:0] score,
`ifdef SPEED_SCHED_BOOST_EN
  input  logic        button_boost,
`endif
  output logic        step_valid,
  output logic [3:0]  step_px,
  output logic [2:0]  speed_level,
  output logic        level_up_pulse
);

  localparam int SUM_W = FRAC_BITS + 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t               state_q;
  logic [FRAC_BITS-1:0] acc_q;
  logic [2:0]           speed_level_q;
  logic [3:0]           prev_hund_q;
  logic                 step_valid_q;
  logic [3:0]           step_px_q;
  logic                 level_up_pulse_q;

  logic [SUM_W-1:0]     inc_base_d;
  logic [SUM_W-1:0]     inc_d;
  logic [SUM_W-1:0]     sum_d;
  logic                 hund_chg_d;
  logic                 level_room_d;
  logic                 unused_score;

  assign unused_score = ^{score[15:12], score[7:0]};

  assign inc_base_d = SUM_W'(BASE_INC) + SUM_W'(speed_level_q) * SUM_W'(LEVEL_INC);

`ifdef SPEED_SCHED_BOOST_EN
  assign inc_d = button_boost ? {inc_base_d[SUM_W-2:0], 1'b0} : inc_base_d;
`else
  assign inc_d = inc_base_d;
`endif

  // The sum is exactly FRAC_BITS+4 wide, so the integer part always fits step_px.
  assign sum_d        = {4'b0000, acc_q} + inc_d;
  assign hund_chg_d   = (score[11:8] != prev_hund_q);
  assign level_room_d = (speed_level_q < 3'(MAX_LEVEL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      acc_q            <= '0;
      speed_level_q    <= '0;
      prev_hund_q      <= '0;
      step_valid_q     <= 1'b0;
      step_px_q        <= '0;
      level_up_pulse_q <= 1'b0;
    end else begin
      step_valid_q     <= 1'b0;
      level_up_pulse_q <= 1'b0;
      if (game_start) begin
        state_q       <= RUN;
        acc_q         <= '0;
        speed_level_q <= '0;
        prev_hund_q   <= score[11:8];
      end else begin
        case (state_q)
          RUN: begin
            if (game_frozen) begin
              state_q <= FROZEN;
            end else begin
              // Tick uses the level registered before any same-cycle level-up.
              if (game_tick) begin
                step_valid_q <= 1'b1;
                step_px_q    <= sum_d[SUM_W-1:FRAC_BITS];
                acc_q        <= sum_d[FRAC_BITS-1:0];
              end
              if (hund_chg_d) begin
                prev_hund_q <= score[11:8];
                if (level_room_d) begin
                  speed_level_q    <= speed_level_q + 3'd1;
                  level_up_pulse_q <= 1'b1;
                end
              end
            end
          end
          IDLE:    state_q <= IDLE;
          FROZEN:  state_q <= FROZEN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign step_valid     = step_valid_q;
  assign step_px        = step_px_q;
  assign speed_level    = speed_level_q;
  assign level_up_pulse = level_up_pulse_q;

endmodule

// File: tb/tb_obstacle_speed_scheduler.sv
// Directed bench for obstacle_speed_scheduler: a per-cycle vector table plus
// hand sequences for level saturation, async reset and (when built in) boost.
module tb_obstacle_speed_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_tick, game_start, game_frozen;
  logic [15:0] score;
`ifdef SPEED_SCHED_BOOST_EN
  logic        button_boost;
`endif
  logic        step_valid;
  logic [3:0]  step_px;
  logic [2:0]  speed_level;
  logic        level_up_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obstacle_speed_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_tick      (game_tick),
    .game_start     (game_start),
    .game_frozen    (game_frozen),
    .score          (score),
`ifdef SPEED_SCHED_BOOST_EN
    .button_boost   (button_boost),
`endif
    .step_valid     (step_valid),
    .step_px        (step_px),
    .speed_level    (speed_level),
    .level_up_pulse (level_up_pulse)
  );

  typedef struct {
    logic        st;
    logic        tk;
    logic        fz;
    logic [15:0] sc;
    logic        v;
    logic [3:0]  px;
    logic [2:0]  lvl;
    logic        pu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, tk, fz, input logic [15:0] sc,
                     input logic v, input logic [3:0] px, input logic [2:0] lvl, input logic pu);
    vec_t r;
    r.st = st; r.tk = tk; r.fz = fz; r.sc = sc;
    r.v = v; r.px = px; r.lvl = lvl; r.pu = pu;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int v, input int px, input int lvl, input int pu);
    chk({nm, ".step_valid"}, int'(step_valid), v);
    chk({nm, ".step_px"}, int'(step_px), px);
    chk({nm, ".speed_level"}, int'(speed_level), lvl);
    chk({nm, ".level_up_pulse"}, int'(level_up_pulse), pu);
  endtask

  // Apply one cycle of inputs, then sample just after the active edge.
  task automatic cyc(input logic st, tk, fz, input logic [15:0] sc);
    game_start = st; game_tick = tk; game_frozen = fz; score = sc;
    @(posedge clk);
    #1;
    game_start = 1'b0; game_tick = 1'b0; game_frozen = 1'b0;
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; game_tick = 1'b0; game_start = 1'b0; game_frozen = 1'b0; score = '0;
`ifdef SPEED_SCHED_BOOST_EN
    button_boost = 1'b0;
`endif

    //   st tk fz score        v  px lvl pu
    add(0, 1, 0, 16'h0000,    0, 0, 0, 0);  // tick in IDLE ignored
    add(1, 0, 0, 16'h0000,    0, 0, 0, 0);
    add(0, 1, 0, 16'h0000,    1, 1, 0, 0);
    add(0, 0, 0, 16'h0000,    0, 1, 0, 0);
    add(0, 1, 0, 16'h0000,    1, 1, 0, 0);
    add(0, 1, 0, 16'h0000,    1, 1, 0, 0);
    add(0, 1, 0, 16'h0000,    1, 1, 0, 0);
    add(0, 0, 0, 16'h0000,    0, 1, 0, 0);
    add(0, 0, 0, 16'h0100,    0, 1, 1, 1);
    add(0, 0, 0, 16'h0100,    0, 1, 1, 0);
    add(0, 1, 0, 16'h0200,    1, 1, 2, 1);  // tick uses old level: 0+20 -> 1, acc 4
    add(0, 1, 0, 16'h0200,    1, 1, 2, 0);  // 4+24=28
    add(0, 1, 0, 16'h0200,    1, 2, 2, 0);  // 12+24=36
    add(0, 1, 0, 16'h0200,    1, 1, 2, 0);
    add(0, 1, 0, 16'h0200,    1, 2, 2, 0);
    add(0, 0, 0, 16'h0200,    0, 2, 2, 0);
    add(0, 1, 1, 16'h0200,    0, 2, 2, 0);  // frozen beats tick
    add(0, 1, 0, 16'h0200,    0, 2, 2, 0);  // FROZEN ignores ticks
    add(0, 0, 0, 16'h0300,    0, 2, 2, 0);  // no level-up outside RUN
    add(1, 1, 0, 16'h0300,    0, 2, 0, 0);  // start beats tick
    add(0, 1, 0, 16'h0300,    1, 1, 0, 0);
    add(1, 0, 0, 16'h0999,    0, 1, 0, 0);
    add(0, 0, 0, 16'h1000,    0, 1, 1, 1);  // hundreds 9 -> 0 wrap
    add(0, 0, 0, 16'h1000,    0, 1, 1, 0);
    add(0, 1, 0, 16'h1000,    1, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].tk, tbl[i].fz, tbl[i].sc);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].v), int'(tbl[i].px),
              int'(tbl[i].lvl), int'(tbl[i].pu));
    end

    // Level saturation: 8 hundreds changes, only the first 7 pulse.
    cyc(1, 0, 0, 16'h0000);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 16'(k << 8));
      pulses += int'(level_up_pulse);
      chk($sformatf("sat%0d.pulse", k), int'(level_up_pulse), (k <= 7) ? 1 : 0);
      chk($sformatf("sat%0d.level", k), int'(speed_level), (k <= 7) ? k : 7);
    end
    chk("sat.pulse_count", pulses, 7);
    cyc(0, 1, 0, 16'h0800);                  // 0+44=44 -> 2, acc 12
    chk_all("sat.tick1", 1, 2, 7, 0);
    cyc(0, 1, 0, 16'h0800);                  // 12+44=56 -> 3
    chk_all("sat.tick2", 1, 3, 7, 0);

    // Asynchronous reset mid-RUN at level 3.
    cyc(1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0100);
    cyc(0, 0, 0, 16'h0200);
    cyc(0, 0, 0, 16'h0300);
    chk_all("pre_rst.lvl", 0, 3, 3, 1);
    cyc(0, 1, 0, 16'h0300);                  // 0+28 -> 1
    chk_all("pre_rst.tick", 1, 1, 3, 0);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 16'h0300);
      chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 16'h0300);
    cyc(0, 1, 0, 16'h0300);
    chk_all("post_rst.start_tick", 1, 1, 0, 0);

`ifdef SPEED_SCHED_BOOST_EN
    cyc(1, 0, 0, 16'h0000);
    button_boost = 1'b1;
    cyc(0, 1, 0, 16'h0000);
    chk_all("boost1", 1, 2, 0, 0);
    cyc(0, 1, 0, 16'h0000);
    chk_all("boost2", 1, 2, 0, 0);
    button_boost = 1'b0;
    cyc(0, 1, 0, 16'h0000);
    chk_all("boost_off", 1, 1, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
